// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
// truth_table_checker : sweeps all input vectors into two implementations of
// one function and counts the vectors on which their outputs disagree.
// Revision: 1.0
// ============================================================================
module truth_table_checker #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [N_IN-1:0]   vec,
   input  logic              s1,
   input  logic              s2,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     mismatch_count,
   output logic              fail_valid,
   output logic [N_IN-1:0]   first_fail,
   output logic              chk_valid,
   output logic              chk_ok
);

   localparam int c_CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

   localparam logic [N_IN-1:0]    c_VEC_LAST = '1;
   localparam logic [N_IN-1:0]    c_VEC_ONE  = N_IN'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(SETTLE);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_WAIT  = 2'd1;
   localparam logic [1:0] c_ST_CHECK = 2'd2;
   localparam logic [1:0] c_ST_DONE  = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [c_CNT_W-1:0] r_cnt;
   logic [N_IN-1:0]    r_vec;
   logic [N_IN:0]      r_mismatch_count;
   logic               r_fail_valid;
   logic [N_IN-1:0]    r_first_fail;
   logic               r_done;
   logic               r_pass;
   logic               r_chk_valid;
   logic               r_chk_ok;

   logic               w_mis;
   logic [N_IN:0]      w_count_next;

   assign w_mis        = s1 ^ s2;
   assign w_count_next = r_mismatch_count + {{N_IN{1'b0}}, w_mis};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_ST_IDLE, c_ST_DONE: if (start) w_state_next = c_ST_WAIT;
         c_ST_WAIT:            if (r_cnt == c_CNT_MAX) w_state_next = c_ST_CHECK;
         c_ST_CHECK:           w_state_next = (r_vec == c_VEC_LAST) ? c_ST_DONE : c_ST_WAIT;
         default:              w_state_next = c_ST_IDLE;
      endcase
   end

   // Sweep datapath; results only move on a start edge or in CHECK
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt            <= '0;
         r_vec            <= '0;
         r_mismatch_count <= '0;
         r_fail_valid     <= 1'b0;
         r_first_fail     <= '0;
         r_done           <= 1'b0;
         r_pass           <= 1'b0;
         r_chk_valid      <= 1'b0;
         r_chk_ok         <= 1'b0;
      end else begin
         r_chk_valid <= 1'b0;
         r_chk_ok    <= 1'b0;
         case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
               if (start) begin
                  r_vec            <= '0;
                  r_cnt            <= '0;
                  r_mismatch_count <= '0;
                  r_fail_valid     <= 1'b0;
                  r_first_fail     <= '0;
                  r_done           <= 1'b0;
                  r_pass           <= 1'b0;
               end
            end
            c_ST_WAIT: begin
               if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + c_CNT_ONE;
            end
            c_ST_CHECK: begin
               r_chk_valid      <= 1'b1;
               r_chk_ok         <= ~w_mis;
               r_mismatch_count <= w_count_next;
               if (w_mis && !r_fail_valid) begin
                  r_fail_valid <= 1'b1;
                  r_first_fail <= r_vec;
               end
               if (r_vec == c_VEC_LAST) begin
                  r_done <= 1'b1;
                  r_pass <= (w_count_next == '0);
               end else begin
                  r_vec <= r_vec + c_VEC_ONE;
                  r_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      busy = (r_state == c_ST_WAIT) || (r_state == c_ST_CHECK);
   end

   assign vec            = r_vec;
   assign done           = r_done;
   assign pass           = r_pass;
   assign mismatch_count = r_mismatch_count;
   assign fail_valid     = r_fail_valid;
   assign first_fail     = r_first_fail;
   assign chk_valid      = r_chk_valid;
   assign chk_ok         = r_chk_ok;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
// tb_truth_table_checker : sweeps three checker instances (SETTLE 1/0/3) with
// bench-modelled implementations and scoreboards every compare pulse.
// Revision: 1.0
// ============================================================================
module tb_truth_table_checker;

   localparam int c_NDUT = 3;

   typedef struct {
      int k;
      int md;
      int cyc;
      int cnt;
      int first;
      bit fv;
      bit ps;
   } tv_t;

   typedef struct {
      int nv;
      bit ok;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_s      [c_NDUT];
   logic [3:0] vec_s        [c_NDUT];
   logic       s1_s         [c_NDUT];
   logic       s2_s         [c_NDUT];
   logic       busy_s       [c_NDUT];
   logic       done_s       [c_NDUT];
   logic       pass_s       [c_NDUT];
   logic [4:0] cnt_s        [c_NDUT];
   logic       fail_valid_s [c_NDUT];
   logic [3:0] first_fail_s [c_NDUT];
   logic       chk_valid_s  [c_NDUT];
   logic       chk_ok_s     [c_NDUT];
   int         mode_s       [c_NDUT];

   int   n_pass = 0;
   int   n_total = 0;
   int   act = 0;
   exp_t q[$];
   tv_t  tab[5];

   always #5 clk = ~clk;

   function automatic logic f_ref(input logic [3:0] v);
      return v[3] & (~v[2] | ~v[0]);
   endfunction

   for (genvar k = 0; k < c_NDUT; k++) begin : g_dut
      localparam int c_S = (k == 0) ? 1 : ((k == 1) ? 0 : 3);
      // mode 1 flips s2 only at vector 13, mode 2 flips it everywhere
      assign s1_s[k] = f_ref(vec_s[k]);
      assign s2_s[k] = f_ref(vec_s[k]) ^ ((mode_s[k] == 2) || (mode_s[k] == 1 && vec_s[k] == 4'd13));
      truth_table_checker #(.N_IN(4), .SETTLE(c_S)) u_dut (
         .clk            (clk),
         .rst            (rst),
         .start          (start_s[k]),
         .vec            (vec_s[k]),
         .s1             (s1_s[k]),
         .s2             (s2_s[k]),
         .busy           (busy_s[k]),
         .done           (done_s[k]),
         .pass           (pass_s[k]),
         .mismatch_count (cnt_s[k]),
         .fail_valid     (fail_valid_s[k]),
         .first_fail     (first_fail_s[k]),
         .chk_valid      (chk_valid_s[k]),
         .chk_ok         (chk_ok_s[k])
      );
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
   endtask

   task automatic check_zero(input int k, input string tag);
      chk({tag, "_vec"},        vec_s[k], 0);
      chk({tag, "_busy"},       busy_s[k], 0);
      chk({tag, "_done"},       done_s[k], 0);
      chk({tag, "_pass"},       pass_s[k], 0);
      chk({tag, "_count"},      cnt_s[k], 0);
      chk({tag, "_fail_valid"}, fail_valid_s[k], 0);
      chk({tag, "_first_fail"}, first_fail_s[k], 0);
      chk({tag, "_chk_valid"},  chk_valid_s[k], 0);
      chk({tag, "_chk_ok"},     chk_ok_s[k], 0);
   endtask

   task automatic push_sweep(input int md);
      exp_t e;
      for (int v = 0; v < 16; v++) begin
         e.nv = (v == 15) ? 15 : v + 1;
         e.ok = !(md == 2 || (md == 1 && v == 13));
         q.push_back(e);
      end
   endtask

   // hold > 0 keeps start asserted for that many cycles into the sweep
   task automatic run_sweep(input int k, input int md, input int hold, input int exp_cyc,
                            input int exp_cnt, input int exp_first, input bit exp_fv,
                            input bit exp_ps, input string tag);
      int cyc;
      mode_s[k] = md;
      act = k;
      q.delete();
      push_sweep(md);
      @(negedge clk);
      start_s[k] = 1'b1;
      @(posedge clk);
      #1;
      if (hold == 0) start_s[k] = 1'b0;
      chk({tag, "_start_busy"},  busy_s[k], 1);
      chk({tag, "_start_done"},  done_s[k], 0);
      chk({tag, "_start_count"}, cnt_s[k], 0);
      chk({tag, "_start_fv"},    fail_valid_s[k], 0);
      cyc = 0;
      while (!done_s[k] && cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == hold) start_s[k] = 1'b0;
      end
      start_s[k] = 1'b0;
      chk({tag, "_latency"},    cyc, exp_cyc);
      chk({tag, "_count"},      cnt_s[k], exp_cnt);
      chk({tag, "_first_fail"}, first_fail_s[k], exp_first);
      chk({tag, "_fail_valid"}, fail_valid_s[k], exp_fv);
      chk({tag, "_pass"},       pass_s[k], exp_ps);
      chk({tag, "_busy_end"},   busy_s[k], 0);
      @(negedge clk);
      #1;
      chk({tag, "_pulses_left"}, q.size(), 0);
      chk({tag, "_vec_hold"},    vec_s[k], 15);
   endtask

   // Scoreboard: each compare pulse pops one expected record
   always @(negedge clk) begin
      for (int k = 0; k < c_NDUT; k++) begin
         if (chk_valid_s[k] === 1'b1) begin
            if (k != act || q.size() == 0) begin
               chk("chk_unexpected_pulse", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("chk_ok", chk_ok_s[k], e.ok);
               chk("chk_vec", vec_s[k], e.nv);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      for (int k = 0; k < c_NDUT; k++) begin
         start_s[k] = 1'b0;
         mode_s[k]  = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < c_NDUT; k++) check_zero(k, "reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      tab[0] = '{k:0, md:0, cyc:48, cnt:0,  first:0,  fv:1'b0, ps:1'b1};
      tab[1] = '{k:0, md:1, cyc:48, cnt:1,  first:13, fv:1'b1, ps:1'b0};
      tab[2] = '{k:0, md:2, cyc:48, cnt:16, first:0,  fv:1'b1, ps:1'b0};
      tab[3] = '{k:1, md:0, cyc:32, cnt:0,  first:0,  fv:1'b0, ps:1'b1};
      tab[4] = '{k:2, md:0, cyc:80, cnt:0,  first:0,  fv:1'b0, ps:1'b1};
      for (int i = 0; i < 5; i++) begin
         run_sweep(tab[i].k, tab[i].md, 0, tab[i].cyc, tab[i].cnt, tab[i].first,
                   tab[i].fv, tab[i].ps, $sformatf("tab%0d", i));
      end

      // Asynchronous reset in the middle of a sweep
      mode_s[0] = 0;
      act = 0;
      q.delete();
      push_sweep(0);
      @(negedge clk);
      start_s[0] = 1'b1;
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      for (int i = 0; i < 100 && vec_s[0] != 4'd5; i++) @(negedge clk);
      chk("rst_mid_reached_vec5", vec_s[0], 5);
      #2;
      rst = 1'b1;
      #1;
      q.delete();
      check_zero(0, "rst_mid");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_idle_busy", busy_s[0], 0);
      chk("rst_idle_vec", vec_s[0], 0);
      run_sweep(0, 0, 0, 48, 0, 0, 1'b0, 1'b1, "post_rst");

      // start held through most of a sweep, then a restart from DONE
      run_sweep(0, 1, 30, 48, 1, 13, 1'b1, 1'b0, "hold_start");
      run_sweep(0, 1, 0, 48, 1, 13, 1'b1, 1'b0, "restart");

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Sequential stimulus and response checker for the two-implementation equivalence exercises: "normal" expression vs "simplified" expression of the same 4-input function.
- Walks every input vector and drives it to both implementations.
- After a settle delay, samples both outputs and compares them.
- Accumulates a mismatch count and the first failing vector, so equivalence is checked in hardware rather than read by eye from a printed table.

Parameters:
- N_IN, 4, number of function inputs; vectors run 0 .. 2^N_IN-1. vec[N_IN-1] maps to x, vec[0] to z.
- SETTLE, 1, extra wait cycles after a vector change before sampling (>=0).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE or DONE
- vec  output  N_IN  current input vector driven to both implementations
- s1  input  1  output of the normal implementation
- s2  input  1  output of the simplified implementation
- busy  output  1  sweep in progress
- done  output  1  sweep complete; held until next start
- pass  output  1  done && mismatch_count==0
- mismatch_count  output  N_IN+1  number of vectors with s1!=s2 (max 2^N_IN, no saturation needed)
- fail_valid  output  1  at least one mismatch recorded this sweep
- first_fail  output  N_IN  vector of the first mismatch; valid when fail_valid
- chk_valid  output  1  one-cycle pulse per compared vector
- chk_ok  output  1  s1==s2 for the vector compared; valid with chk_valid

Behaviour:
- Reset (async, any state): state=IDLE; vec=0, busy=0, done=0, pass=0, mismatch_count=0, fail_valid=0, first_fail=0, chk_valid=0, chk_ok=0. Reset mid-sweep discards all results.
- States: IDLE, WAIT, CHECK, DONE. Internal settle counter cnt has width clog2(SETTLE+1), minimum 1 bit.
- IDLE/DONE with start=1:
  - vec<=0, cnt<=0.
  - Clear mismatch_count, fail_valid, first_fail, done, pass.
  - Go to WAIT.
- IDLE/DONE with start=0: hold all outputs.
- WAIT: if cnt==SETTLE go to CHECK, else cnt<=cnt+1. WAIT therefore lasts SETTLE+1 cycles per vector.
- CHECK (one cycle):
  - s1 and s2 are sampled this cycle; chk_valid=1 and chk_ok=(s1==s2) are registered, visible the following cycle for exactly one cycle.
  - On mismatch: mismatch_count+=1. If fail_valid==0, set first_fail<=vec and fail_valid<=1.
  - If vec==2^N_IN-1: go to DONE, done<=1, pass<=(final count==0), vec holds.
  - Otherwise: vec<=vec+1, cnt<=0, go to WAIT.
- Per vector: SETTLE+2 cycles. Full sweep: 2^N_IN*(SETTLE+2) cycles from the start edge to done rising (default 48).
- busy=1 exactly in WAIT and CHECK.
- start is ignored while busy; a long start pulse in DONE restarts once, on the first sampled edge.
- vec changes only on entry to a new vector, so it is stable throughout WAIT and CHECK.
- s1/s2 are not sampled outside CHECK; glitches during WAIT are ignored.
- No wrap-around: vec never increments past 2^N_IN-1.
- The counter never overflows: at most 2^N_IN increments into N_IN+1 bits.

Test Plan:
1. Equivalent implementations (s1=s2=x&(~y|~z) from vec), default params, start pulse → 16 chk_valid pulses all chk_ok=1; done rises 48 cycles after start; pass=1, mismatch_count=0, fail_valid=0.
2. s2 forced inverted only at vec=13 (x=1,y=1,w=0,z=1) → mismatch_count=1, first_fail=13, fail_valid=1, pass=0; chk_ok=0 only for the 14th pulse.
3. s2=~s1 for all vectors → mismatch_count=16 (5'b10000), first_fail=0, pass=0.
4. rst asserted asynchronously mid-cycle while vec=5 → all outputs zero immediately (before next edge), state IDLE; new start gives a clean full sweep with case-1 results.
5. start held high throughout a sweep, then a second start from DONE after case-2 stimulus → no restart while busy; on restart, count/fail cleared at the start edge and the sweep repeats with identical results.
6. SETTLE=0 instance → 2 cycles per vector, done 32 cycles after start; SETTLE=3 → 5 cycles per vector, done after 80 cycles; results as in case 1.
